// File: rtl/gearbox_ser_if.sv
// Handshake bundle for the parallel-to-serial gearbox: word side in, beat side out.
interface gearbox_ser_if #(
   parameter int DATA_W    = 8,
   parameter int LANE_W    = 1,
   parameter int BUF_DEPTH = 2
);
   logic [DATA_W-1:0]                  data_i;
   logic                               valid_i;
   logic                               ready_o;
   logic [LANE_W-1:0]                  data_o;
   logic                               valid_o;
   logic                               ready_i;
   logic                               last_o;
   logic [$clog2(BUF_DEPTH+1)-1:0]     level_o;

   modport master (
      output data_i, valid_i, ready_i,
      input  ready_o, data_o, valid_o, last_o, level_o
   );

   modport slave (
      input  data_i, valid_i, ready_i,
      output ready_o, data_o, valid_o, last_o, level_o
   );
endinterface

// File: rtl/gearbox_ser.sv
// Parallel-to-serial gearbox: buffered DATA_W words are emitted as LANE_W-bit beats,
// with a bypass path into the shifter and no bubble between consecutive words.
module gearbox_ser #(
   parameter int DATA_W    = 8,
   parameter int LANE_W    = 1,
   parameter int MSB_FIRST = 1,
   parameter int BUF_DEPTH = 2
) (
   input logic          clk_i,
   input logic          rst_i,
   gearbox_ser_if.slave bus
);
   localparam int BEATS = DATA_W / LANE_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int LVL_W = $clog2(BUF_DEPTH + 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]        state;
   logic [CNT_W-1:0]  beat_cnt;
   logic [DATA_W-1:0] shift_word;
   logic [DATA_W-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level;

   logic ready;
   logic valid;
   logic is_last;
   logic push;
   logic beat_done;
   logic last_done;
   logic free;
   logic pop;
   logic bypass;
   logic fifo_wr;

   function automatic logic [LANE_W-1:0] head_lane(input logic [DATA_W-1:0] w);
      if (MSB_FIRST != 0) return w[DATA_W-1 -: LANE_W];
      else                return w[LANE_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
      if (MSB_FIRST != 0) return w << LANE_W;
      else                return w >> LANE_W;
   endfunction

   assign ready     = (level < LVL_W'(BUF_DEPTH));
   assign valid     = (state == SHIFT);
   assign is_last   = valid && (beat_cnt == CNT_W'(BEATS - 1));
   assign push      = bus.valid_i && ready;
   assign beat_done = valid && bus.ready_i;
   assign last_done = beat_done && is_last;

   // The shifter can take a new word when idle or when its final beat completes this edge.
   assign free      = (state == IDLE) || last_done;
   assign pop       = free && (level != '0);
   assign bypass    = free && (level == '0) && push;
   assign fifo_wr   = push && !bypass;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         beat_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({fifo_wr, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         if (pop || bypass) begin
            state    <= SHIFT;
            beat_cnt <= '0;
         end else if (last_done) begin
            state    <= IDLE;
            beat_cnt <= '0;
         end else if (beat_done) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
      end
   end

   // Word storage carries no reset; control above decides what is live.
   always_ff @(posedge clk_i) begin
      if (fifo_wr && rst_i) mem[wr_ptr] <= bus.data_i;
   end

   always_ff @(posedge clk_i) begin
      if (pop)            shift_word <= mem[rd_ptr];
      else if (bypass)    shift_word <= bus.data_i;
      else if (beat_done) shift_word <= advance(shift_word);
   end

   assign bus.ready_o = ready;
   assign bus.valid_o = valid;
   assign bus.last_o  = is_last;
   assign bus.level_o = level;
   assign bus.data_o  = valid ? head_lane(shift_word) : '0;
endmodule

// File: tb/tb_gearbox_ser.sv
// Directed bench for gearbox_ser: MSB-first 1-bit default instance plus an LSB-first 2-bit instance.
module tb_gearbox_ser;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   gearbox_ser_if #(.DATA_W(8), .LANE_W(1), .BUF_DEPTH(2)) bus_a ();
   gearbox_ser_if #(.DATA_W(8), .LANE_W(2), .BUF_DEPTH(2)) bus_b ();

   gearbox_ser #(.DATA_W(8), .LANE_W(1), .MSB_FIRST(1), .BUF_DEPTH(2)) u_dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_a)
   );

   gearbox_ser #(.DATA_W(8), .LANE_W(2), .MSB_FIRST(0), .BUF_DEPTH(2)) u_dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push_a(input logic [7:0] w);
      bus_a.valid_i = 1'b1;
      bus_a.data_i  = w;
      step();
      bus_a.valid_i = 1'b0;
   endtask

   // Expects one full word on instance A with ready_i held high.
   task automatic expect_word_a(input logic [7:0] w, input string tag);
      for (int k = 0; k < 8; k++) begin
         chk({tag, "_valid"}, bus_a.valid_o, 1'b1);
         chk({tag, "_data"},  bus_a.data_o,  w[7-k]);
         chk({tag, "_last"},  bus_a.last_o,  (k == 7));
         step();
      end
   endtask

   task automatic run_stream(input int n, input bit rand_ready, input int budget, input string tag);
      logic [7:0] words[$];
      logic [1:0] q[$];
      logic [7:0] wv;
      int         idx = 0;
      int         gaps = 0;
      int         beats = 0;
      bit         started = 0;
      bit         stalled = 0;
      bit         done = 0;
      logic       hold_d = 1'b0;
      logic       hold_l = 1'b0;
      for (int i = 0; i < n; i++) words.push_back(8'($urandom));
      for (int cyc = 0; cyc < budget && !done; cyc++) begin
         bus_a.ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stalled) begin
            chk({tag, "_hold_data"}, bus_a.data_o, hold_d);
            chk({tag, "_hold_last"}, bus_a.last_o, hold_l);
         end
         if (bus_a.valid_o) begin
            started = 1;
            if (q.size() == 0) begin
               chk({tag, "_extra_beat"}, 1, 0);
            end else begin
               chk({tag, "_data"}, bus_a.data_o, q[0][0]);
               chk({tag, "_last"}, bus_a.last_o, q[0][1]);
               if (bus_a.ready_i) begin
                  q.delete(0);
                  beats++;
               end
            end
            stalled = !bus_a.ready_i;
            hold_d  = bus_a.data_o;
            hold_l  = bus_a.last_o;
         end else begin
            stalled = 0;
            if (started && q.size() > 0) gaps++;
         end
         if (idx < n) begin
            wv = words[idx];
            bus_a.valid_i = 1'b1;
            bus_a.data_i  = wv;
            if (bus_a.ready_o) begin
               for (int k = 0; k < 8; k++) q.push_back({(k == 7), wv[7-k]});
               idx++;
            end
         end else begin
            bus_a.valid_i = 1'b0;
         end
         if (idx == n && q.size() == 0) done = 1;
         step();
      end
      bus_a.valid_i = 1'b0;
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_gaps"}, gaps, 0);
      chk({tag, "_beats"}, beats, n * 8);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] lanes_b [4];
      logic [7:0] w;
      lanes_b = '{2'b00, 2'b01, 2'b11, 2'b10};

      rst = 1'b0;
      bus_a.valid_i = 1'b0; bus_a.data_i = '0; bus_a.ready_i = 1'b0;
      bus_b.valid_i = 1'b0; bus_b.data_i = '0; bus_b.ready_i = 1'b0;
      step();
      step();
      chk("rst_valid", bus_a.valid_o, 1'b0);
      chk("rst_level", bus_a.level_o, 0);
      chk("rst_ready", bus_a.ready_o, 1'b1);
      chk("rst_last",  bus_a.last_o,  1'b0);
      chk("rst_data",  bus_a.data_o,  0);
      chk("rst_b_valid", bus_b.valid_o, 1'b0);
      rst = 1'b1;

      // Single word, MSB first
      bus_a.ready_i = 1'b1;
      push_a(8'hA5);
      expect_word_a(8'hA5, "a5");
      chk("a5_idle", bus_a.valid_o, 1'b0);

      // LSB first, 2-bit lanes
      bus_b.ready_i = 1'b1;
      bus_b.valid_i = 1'b1;
      bus_b.data_i  = 8'hB4;
      step();
      bus_b.valid_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("b4_valid", bus_b.valid_o, 1'b1);
         chk("b4_data",  bus_b.data_o,  lanes_b[k]);
         chk("b4_last",  bus_b.last_o,  (k == 3));
         step();
      end
      chk("b4_idle", bus_b.valid_o, 1'b0);

      run_stream(10, 1'b0, 400, "burst");
      bus_a.ready_i = 1'b1;
      repeat (3) step();
      chk("burst_idle", bus_a.valid_o, 1'b0);

      // Back-pressure fills the buffer
      bus_a.ready_i = 1'b0;
      push_a(8'h3C);
      chk("bp_level0", bus_a.level_o, 0);
      chk("bp_valid",  bus_a.valid_o, 1'b1);
      push_a(8'h81);
      chk("bp_level1", bus_a.level_o, 1);
      push_a(8'hE7);
      chk("bp_level2", bus_a.level_o, 2);
      chk("bp_ready",  bus_a.ready_o, 1'b0);
      bus_a.valid_i = 1'b1;
      bus_a.data_i  = 8'h55;
      repeat (3) step();
      chk("bp_full_level", bus_a.level_o, 2);
      chk("bp_full_ready", bus_a.ready_o, 1'b0);
      chk("bp_held_data",  bus_a.data_o,  1'b0);
      bus_a.valid_i = 1'b0;
      bus_a.ready_i = 1'b1;
      expect_word_a(8'h3C, "bp_w0");
      expect_word_a(8'h81, "bp_w1");
      expect_word_a(8'hE7, "bp_w2");
      chk("bp_drained_valid", bus_a.valid_o, 1'b0);
      chk("bp_drained_level", bus_a.level_o, 0);

      run_stream(50, 1'b1, 3000, "stall");
      bus_a.ready_i = 1'b1;
      repeat (3) step();

      // Reset mid-word with two words buffered
      bus_a.ready_i = 1'b0;
      push_a(8'h11);
      push_a(8'h22);
      push_a(8'h33);
      bus_a.ready_i = 1'b1;
      repeat (3) step();
      chk("mid_level", bus_a.level_o, 2);
      w = 8'h11;
      chk("mid_beat3", bus_a.data_o, w[4]);
      rst = 1'b0;
      bus_a.valid_i = 1'b1;
      bus_a.data_i  = 8'hFF;
      step();
      chk("mrst_valid", bus_a.valid_o, 1'b0);
      chk("mrst_level", bus_a.level_o, 0);
      chk("mrst_ready", bus_a.ready_o, 1'b1);
      chk("mrst_last",  bus_a.last_o,  1'b0);
      rst = 1'b1;
      bus_a.valid_i = 1'b0;
      step();
      chk("post_rst_valid", bus_a.valid_o, 1'b0);
      chk("post_rst_level", bus_a.level_o, 0);
      push_a(8'h96);
      expect_word_a(8'h96, "post_rst");
      repeat (4) begin
         chk("post_rst_quiet", bus_a.valid_o, 1'b0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gearbox_ser.md
GEARBOX_SER -- requirements
Module: gearbox_ser

Interface
REQ-001 SHALL have parameter DATA_W, default 8: parallel word width in bits.
REQ-002 SHALL have parameter LANE_W, default 1: serial bits per output beat; DATA_W % LANE_W == 0 is required, and BEATS = DATA_W/LANE_W.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 sends the most-significant lane first, 0 sends the least-significant lane first.
REQ-004 SHALL have parameter BUF_DEPTH, default 2: input word buffer entries, a power of 2 and at least 2.
REQ-005 SHALL have clk_i, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-006 SHALL have rst_i, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have data_i, input, DATA_W bits: parallel word in.
REQ-008 SHALL have valid_i, input, 1 bit: data_i valid.
REQ-009 SHALL have ready_o, output, 1 bit: block can accept a word.
REQ-010 SHALL have data_o, output, LANE_W bits: current serial beat.
REQ-011 SHALL have valid_o, output, 1 bit: data_o valid.
REQ-012 SHALL have ready_i, input, 1 bit: downstream accepts the beat.
REQ-013 SHALL have last_o, output, 1 bit: high on the final beat of a word.
REQ-014 SHALL have level_o, output, $clog2(BUF_DEPTH+1) bits: count of words held in the buffer (excluding the shifter).

Function
REQ-015 SHALL accept a word on a rising edge where valid_i && ready_o is true, and only then.
REQ-016 SHALL drive ready_o = (level_o < BUF_DEPTH), decoded from registers only, with no combinational path from valid_i or ready_i.
REQ-017 SHALL contain a shifter with two states: IDLE (no word loaded, valid_o=0) and SHIFT (word loaded, valid_o=1).
REQ-018 SHALL handle a word accepted while IDLE with an empty buffer by loading it directly into the shifter (bypass): valid_o=1 and the first beat appear the cycle after acceptance, with 1-cycle latency.
REQ-019 SHALL otherwise write an accepted word to the FIFO tail, incrementing level_o.
REQ-020 SHALL complete a beat when valid_o && ready_i is true at a rising edge, advancing the internal beat counter 0..BEATS-1.
REQ-021 SHALL hold data_o and last_o stable while valid_o=1 and ready_i=0.
REQ-022 SHALL drive data_o with lane k of the loaded word on beat k, where lane 0 is bits [DATA_W-1 -: LANE_W] when MSB_FIRST=1 and bits [LANE_W-1:0] when MSB_FIRST=0.
REQ-023 SHALL assert last_o iff valid_o=1 and the beat counter equals BEATS-1; when BEATS=1, last_o equals valid_o.
REQ-024 SHALL, on completion of the last beat with the FIFO non-empty, load the FIFO head into the shifter on the same edge and decrement level_o, so there is no bubble between words.
REQ-025 SHALL, on completion of the last beat with the FIFO empty, load a word accepted on that same edge directly into the shifter (bypass) and remain in SHIFT; with no word accepted, it SHALL go to IDLE.
REQ-026 SHALL keep level_o unchanged when a push and a pop occur on the same edge.
REQ-027 SHALL wrap the FIFO read and write pointers modulo BUF_DEPTH.
REQ-028 SHALL ignore data_i while valid_i=0, and SHALL ignore valid_i while ready_o=0 with no state change.
REQ-029 SHALL preserve word order exactly: output beats equal the input words in acceptance order.

Reset
REQ-030 SHALL, when rst_i=0 at a rising edge, set state IDLE, beat counter 0, FIFO pointers 0, level_o=0, valid_o=0, last_o=0, data_o=0 and ready_o=1 from the next cycle.
REQ-031 SHALL, when reset is asserted mid-word, discard the partial word and all buffered words; after deassertion, no beat of the discarded words SHALL appear.
REQ-032 SHALL accept no input on an edge where rst_i=0.

Verification
REQ-033 SHALL be verified at defaults by pushing 8'hA5 with ready_i=1, giving valid_o high one cycle after acceptance, data_o = 1,0,1,0,0,1,0,1, and last_o only on the 8th beat.
REQ-034 SHALL be verified with MSB_FIRST=0, LANE_W=2 by pushing 8'hB4, giving data_o = 2'b00, 2'b01, 2'b11, 2'b10 over 4 beats.
REQ-035 SHALL be verified at defaults by streaming 10 random words back-to-back with ready_i=1, giving 80 consecutive valid_o beats with no gap and all words in order.
REQ-036 SHALL be verified with ready_i=0 while pushing 3 words, giving level_o = 0,1,2, then ready_o=0 and the 4th word not accepted; after ready_i=1 is released, all 3 words are output intact.
REQ-037 SHALL be verified with ready_i toggling randomly every cycle over 50 words, giving data_o held during stalls and an exact in-order bit-stream match against a reference model.
REQ-038 SHALL be verified by asserting rst_i=0 at beat 3 of a word with 2 words buffered, giving valid_o=0 and level_o=0 the next cycle, and a new word pushed after reset arriving first with beat 0.
